// File: rtl/bsg_manycore_event_profiler.sv
// ============================================================================
// Module   : bsg_manycore_event_profiler
// Brief    : Per-tile cycle/event profiler with sticky overflow flags and a
//            valid/ready readout stream of all counters.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bsg_manycore_event_profiler #(
    parameter  int num_events_p    = 8,
    parameter  int counter_width_p = 32,
    parameter  int saturate_p      = 1,
    localparam int idx_width_lp    = (num_events_p + 1 <= 1) ? 1 : $clog2(num_events_p + 1)
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic                       start_i,
    input  logic                       stop_i,
    input  logic [num_events_p-1:0]    event_v_i,
    output logic                       v_o,
    output logic [counter_width_p-1:0] data_o,
    output logic [idx_width_lp-1:0]    idx_o,
    input  logic                       ready_i,
    output logic                       counting_o,
    output logic                       done_o,
    output logic [num_events_p:0]      overflow_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_DUMP  = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e                     state_q;
    logic [idx_width_lp-1:0]    idx_q;
    logic                       v_q;
    logic                       counting_q;
    logic                       done_q;

    logic                       clear;
    logic                       count_en;
    logic                       accept;
    logic                       last_word;
    logic [num_events_p:0]      inc;
    logic [counter_width_p-1:0] cnt_all [num_events_p+1];

    // start is honoured everywhere except during readout, and wins over stop.
    assign clear     = start_i & (state_q != S_DUMP);
    assign count_en  = (state_q == S_COUNT) & ~start_i;
    assign accept    = v_q & ready_i;
    assign last_word = (idx_q == idx_width_lp'(num_events_p));
    assign inc       = {event_v_i, 1'b1};

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            v_q        <= 1'b0;
            counting_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_q    <= S_COUNT;
                        counting_q <= 1'b1;
                    end
                end
                S_COUNT: begin
                    if (!start_i && stop_i) begin
                        state_q    <= S_DUMP;
                        counting_q <= 1'b0;
                        v_q        <= 1'b1;
                        idx_q      <= '0;
                    end
                end
                S_DUMP: begin
                    if (accept) begin
                        if (last_word) begin
                            state_q <= S_DONE;
                            v_q     <= 1'b0;
                            done_q  <= 1'b1;
                            idx_q   <= '0;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (start_i) begin
                        state_q    <= S_COUNT;
                        counting_q <= 1'b1;
                        done_q     <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Slot 0 is the cycle counter (always incrementing), slot k+1 is event k.
    for (genvar k = 0; k <= num_events_p; k++) begin : g_cnt
        logic [counter_width_p-1:0] cnt_q;
        logic [counter_width_p-1:0] cnt_d;
        logic                       ovf_q;
        logic                       ovf_d;

        always_comb begin
            cnt_d = cnt_q;
            ovf_d = ovf_q;
            if (clear) begin
                cnt_d = '0;
                ovf_d = 1'b0;
            end else if (count_en && inc[k]) begin
                if (&cnt_q) begin
                    ovf_d = 1'b1;
                    cnt_d = (saturate_p != 0) ? cnt_q : '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end

        always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
                cnt_q <= '0;
                ovf_q <= 1'b0;
            end else begin
                cnt_q <= cnt_d;
                ovf_q <= ovf_d;
            end
        end

        assign cnt_all[k]    = cnt_q;
        assign overflow_o[k] = ovf_q;
    end

    assign v_o        = v_q;
    assign idx_o      = idx_q;
    assign data_o     = v_q ? cnt_all[idx_q] : '0;
    assign counting_o = counting_q;
    assign done_o     = done_q;

endmodule

`default_nettype wire

// File: tb/tb_bsg_manycore_event_profiler.sv
// ============================================================================
// Module   : tb_bsg_manycore_event_profiler
// Brief    : Self-checking bench: three profiler configurations driven in
//            lockstep and compared against true event totals.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_bsg_manycore_event_profiler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       stop  = 1'b0;
    logic       ready = 1'b0;
    logic [7:0] ev    = '0;

    logic        va, ca, dna;
    logic [31:0] da;
    logic [3:0]  ia;
    logic [8:0]  oa;
    logic        vb, cb, dnb;
    logic [3:0]  db;
    logic [1:0]  ib;
    logic [2:0]  ob;
    logic        vc, cc, dnc;
    logic [3:0]  dc;
    logic [1:0]  ic;
    logic [2:0]  oc;

    bsg_manycore_event_profiler u_a (
        .clk_i(clk), .reset_n_i(rst_n), .start_i(start), .stop_i(stop),
        .event_v_i(ev), .v_o(va), .data_o(da), .idx_o(ia), .ready_i(ready),
        .counting_o(ca), .done_o(dna), .overflow_o(oa)
    );

    bsg_manycore_event_profiler #(.num_events_p(2), .counter_width_p(4), .saturate_p(1)) u_b (
        .clk_i(clk), .reset_n_i(rst_n), .start_i(start), .stop_i(stop),
        .event_v_i(ev[1:0]), .v_o(vb), .data_o(db), .idx_o(ib), .ready_i(ready),
        .counting_o(cb), .done_o(dnb), .overflow_o(ob)
    );

    bsg_manycore_event_profiler #(.num_events_p(2), .counter_width_p(4), .saturate_p(0)) u_c (
        .clk_i(clk), .reset_n_i(rst_n), .start_i(start), .stop_i(stop),
        .event_v_i(ev[1:0]), .v_o(vc), .data_o(dc), .idx_o(ic), .ready_i(ready),
        .counting_o(cc), .done_o(dnc), .overflow_o(oc)
    );

    int     n_vec = 0;
    int     n_err = 0;
    longint t [9];

    // Observable counter value given the true number of increments.
    function automatic longint expv(input longint x, input int w, input bit sat);
        longint m;
        m = longint'(1) << w;
        if (x >= m) return sat ? m - 1 : x % m;
        return x;
    endfunction

    function automatic logic expo(input longint x, input int w);
        return x >= (longint'(1) << w);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int k = 0; k < 9; k++) t[k] = 0;
    endtask

    task automatic count_cycle(input logic [7:0] e, input bit st);
        ev   = e;
        stop = st;
        step();
        t[0]++;
        for (int k = 0; k < 8; k++) if (e[k]) t[k+1]++;
        ev   = '0;
        stop = 1'b0;
        chk("counting", {ca, cb, cc}, st ? 3'b000 : 3'b111);
        chk("valid_after_count", {va, vb, vc}, st ? 3'b111 : 3'b000);
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
        clear_model();
        chk("start_counting", {ca, cb, cc}, 3'b111);
        chk("start_done", {dna, dnb, dnc}, 3'b000);
        chk("start_ovf", {oa, ob, oc}, 15'd0);
    endtask

    // mode 0: ready held high, 1: random ready, 2: repeating 1,0,0,1.
    task automatic drain(input int mode, input int start_at);
        int ea, eb, ec, cyc;
        bit fin, r;
        logic [3:0] pat;
        ea = 0; eb = 0; ec = 0; cyc = 0; fin = 1'b0;
        pat = 4'b1001;
        while (!fin && cyc < 200) begin
            if (ea <= 8) begin
                chk("a_valid", va, 1'b1);
                chk("a_idx", ia, ea);
                chk("a_data", da, expv(t[ea], 32, 1'b1));
            end else begin
                chk("a_valid_end", va, 1'b0);
                chk("a_done", dna, 1'b1);
            end
            if (eb <= 2) begin
                chk("b_idx", {vb, ib}, {1'b1, 2'(eb)});
                chk("b_data", db, expv(t[eb], 4, 1'b1));
            end else begin
                chk("b_end", {vb, dnb}, 2'b01);
            end
            if (ec <= 2) begin
                chk("c_idx", {vc, ic}, {1'b1, 2'(ec)});
                chk("c_data", dc, expv(t[ec], 4, 1'b0));
            end else begin
                chk("c_end", {vc, dnc}, 2'b01);
            end
            fin = (ea > 8) && (eb > 2) && (ec > 2);
            if (!fin) begin
                case (mode)
                    0:       r = 1'b1;
                    1:       r = 1'($urandom_range(0, 1));
                    default: r = pat[cyc % 4];
                endcase
                ready = r;
                start = (ea == start_at);
                step();
                start = 1'b0;
                if (r) begin
                    if (ea <= 8) ea++;
                    if (eb <= 2) eb++;
                    if (ec <= 2) ec++;
                end
                cyc++;
            end
        end
        ready = 1'b0;
        if (!fin) chk("drain_timeout", 64'd0, 64'd1);
        for (int k = 0; k < 9; k++) chk("a_ovf", oa[k], expo(t[k], 32));
        for (int k = 0; k < 3; k++) begin
            chk("b_ovf", ob[k], expo(t[k], 4));
            chk("c_ovf", oc[k], expo(t[k], 4));
        end
    endtask

    initial begin
        clear_model();
        repeat (2) step();
        chk("rst_a", {va, ia, da, oa, ca, dna}, 64'd0);
        chk("rst_bc", {vb, ib, db, ob, cb, dnb, vc, ic, dc, oc, cc, dnc}, 64'd0);
        rst_n = 1'b1;
        step();

        // stop while idle does nothing
        stop = 1'b1;
        step();
        stop = 1'b0;
        step();
        chk("idle_stop", {va, ca, vb, cb, vc, cc}, 6'd0);

        // event 2 high for five cycles, stop on the tenth counted cycle
        do_start();
        for (int i = 0; i < 10; i++) count_cycle((i < 5) ? 8'h04 : 8'h00, i == 9);
        drain(0, -1);

        // saturate vs wrap on 4-bit counters
        do_start();
        for (int i = 0; i < 20; i++) count_cycle(8'h01, 1'b0);
        count_cycle(8'h00, 1'b1);
        drain(0, -1);

        // restart from DONE clears flags; readout under 1,0,0,1 backpressure
        do_start();
        for (int i = 0; i < 15; i++) count_cycle(8'($urandom), i == 14);
        drain(2, -1);

        // start and stop together while counting: clear, keep counting
        do_start();
        for (int i = 0; i < 5; i++) count_cycle(8'($urandom), 1'b0);
        start = 1'b1;
        stop  = 1'b1;
        ev    = 8'($urandom);
        step();
        start = 1'b0;
        stop  = 1'b0;
        ev    = '0;
        clear_model();
        chk("startstop_counting", {ca, cb, cc}, 3'b111);
        chk("startstop_valid", {va, vb, vc}, 3'b000);
        for (int i = 0; i < 6; i++) count_cycle(8'($urandom), i == 5);
        drain(1, -1);

        // random runs; the first has a start pulse while word 2 is presented
        for (int r = 0; r < 4; r++) begin
            int n;
            n = $urandom_range(1, 40);
            do_start();
            for (int i = 0; i < n; i++) count_cycle(8'($urandom), i == n - 1);
            drain(1, (r == 0) ? 2 : -1);
        end

        // asynchronous reset in the middle of readout
        do_start();
        for (int i = 0; i < 20; i++) count_cycle(8'h03, i == 19);
        step();
        chk("pre_rst_valid", {va, vb, vc}, 3'b111);
        chk("pre_rst_ovf_b", ob, 3'b111);
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_a", {va, dna, oa, ca}, 12'd0);
        chk("async_rst_bc", {vb, dnb, ob, cb, vc, dnc, oc, cc}, 12'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("post_rst_quiet", {va, ca, vb, cb, vc, cc}, 6'd0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
